pwbal: RTL

Per-channel white-balance gain stage that sits directly downstream of the Bayer demosaic: it consumes the demosaic's packed RGB AXI4-Stream and emits a gain-corrected RGB stream of identical format. Each colour channel is multiplied by an unsigned fixed-point gain, rounded and saturated. Gain changes are frame-synchronous: software writes new gains at any time, and they take effect only on the next start-of-frame beat. The block is fully pipelined, with one beat per cycle and AXI backpressure honoured end to end.

---
 rtl/pwbal_pkg.sv | 27 ++
 rtl/pwbal_if.sv | 27 ++
 rtl/pwbal_chan.sv | 44 ++++
 rtl/pwbal.sv | 104 ++++++++++
 4 files changed

// File: rtl/pwbal_pkg.sv
// pwbal_pkg: shared types and helpers for the white-balance gain stage.
package pwbal_pkg;

    // Sideband flags that travel alongside each pixel beat.
    typedef struct packed {
        logic tuser;
        logic tlast;
    } flags_t;

    // Unity gain value for a gain with 'frac' fractional bits.
    function automatic int unsigned unity_gain(input int unsigned frac);
        return 32'd1 << frac;
    endfunction

    // Half an LSB of the output, added before truncation for round-half-up.
    function automatic int unsigned round_const(input int unsigned frac);
        return 32'd1 << (frac - 32'd1);
    endfunction

    // Clamp q to the largest value representable in 'width' bits.
    function automatic logic [63:0] saturate(input logic [63:0] q, input int unsigned width);
        logic [63:0] max_v;
        max_v = (64'd1 << width) - 64'd1;
        return (q > max_v) ? max_v : q;
    endfunction

endpackage

// File: rtl/pwbal_if.sv
// pwbal_if: input and output AXI4-Stream pixel channels of the gain stage.
interface pwbal_if #(
    parameter int unsigned C_PIXEL_WIDTH = 8
) ();
    logic                       s_axis_tvalid;
    logic                       s_axis_tready;
    logic [3*C_PIXEL_WIDTH-1:0] s_axis_tdata;
    logic                       s_axis_tuser;
    logic                       s_axis_tlast;
    logic                       m_axis_tvalid;
    logic                       m_axis_tready;
    logic [3*C_PIXEL_WIDTH-1:0] m_axis_tdata;
    logic                       m_axis_tuser;
    logic                       m_axis_tlast;

    // Stream source feeding pixels in and sinking corrected pixels.
    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tuser, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
    );

    // The gain stage itself.
    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tuser, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
    );
endinterface

// File: rtl/pwbal_chan.sv
// pwbal_chan: one colour channel, multiply in d1, round and saturate in d2.
module pwbal_chan
    import pwbal_pkg::*;
#(
    parameter int unsigned C_PIXEL_WIDTH = 8,
    parameter int unsigned C_GAIN_WIDTH  = 10,
    parameter int unsigned C_GAIN_FRAC   = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     en_d1_i,
    input  logic                     en_d2_i,
    input  logic [C_PIXEL_WIDTH-1:0] pix_i,
    input  logic [C_GAIN_WIDTH-1:0]  gain_i,
    output logic [C_PIXEL_WIDTH-1:0] q_o
);
    localparam int unsigned PRW = C_PIXEL_WIDTH + C_GAIN_WIDTH;
    localparam int unsigned SW  = PRW + 1;

    logic [PRW-1:0]           prod_q;
    logic [C_PIXEL_WIDTH-1:0] q_q;
    logic [SW-1:0]            sum_d;
    logic [SW-1:0]            shifted_d;

    // Rounded product, one bit wider than the product so the add cannot wrap.
    always_comb begin
        sum_d     = {1'b0, prod_q} + SW'(round_const(C_GAIN_FRAC));
        shifted_d = sum_d >> C_GAIN_FRAC;
    end

    // d1 holds the raw product, d2 the saturated result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prod_q <= '0;
            q_q    <= '0;
        end else begin
            if (en_d1_i) prod_q <= PRW'(pix_i) * PRW'(gain_i);
            if (en_d2_i) q_q    <= C_PIXEL_WIDTH'(saturate(64'(shifted_d), C_PIXEL_WIDTH));
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/pwbal.sv
// pwbal: frame-synchronous per-channel white-balance gain on an RGB stream.
module pwbal
    import pwbal_pkg::*;
#(
    parameter int unsigned C_PIXEL_WIDTH = 8,
    parameter int unsigned C_GAIN_WIDTH  = 10,
    parameter int unsigned C_GAIN_FRAC   = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [C_GAIN_WIDTH-1:0] gain_r,
    input  logic [C_GAIN_WIDTH-1:0] gain_g,
    input  logic [C_GAIN_WIDTH-1:0] gain_b,
    input  logic                    gain_update,
    output logic                    gain_pending,
    pwbal_if.slave                  axis
);
    localparam logic [C_GAIN_WIDTH-1:0] UNITY = C_GAIN_WIDTH'(unity_gain(C_GAIN_FRAC));

    logic                     valid_d1_q, valid_d2_q;
    flags_t                   flags_d1_q, flags_d2_q;
    logic                     ready_d1, ready_d2, en_d1, en_d2, sof_acc;
    logic                     pending_q;
    logic [C_GAIN_WIDTH-1:0]  act_q   [3];
    logic [C_GAIN_WIDTH-1:0]  pnd_q   [3];
    logic [C_GAIN_WIDTH-1:0]  gain_in [3];
    logic [C_GAIN_WIDTH-1:0]  gain_sel[3];
    logic [C_PIXEL_WIDTH-1:0] q_w     [3];

    assign ready_d2 = ~valid_d2_q | axis.m_axis_tready;
    assign ready_d1 = ~valid_d1_q | ready_d2;
    assign en_d1    = ready_d1 & axis.s_axis_tvalid;
    assign en_d2    = ready_d2 & valid_d1_q;
    assign sof_acc  = en_d1 & axis.s_axis_tuser;

    // A SOF beat with a pending set already multiplies by the pending gains.
    always_comb begin
        gain_in[0] = gain_r;
        gain_in[1] = gain_g;
        gain_in[2] = gain_b;
        for (int unsigned i = 0; i < 3; i++) begin
            gain_sel[i] = (axis.s_axis_tuser && pending_q) ? pnd_q[i] : act_q[i];
        end
    end

    // Pending/active gain sets; a same-cycle update overrides the SOF clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < 3; i++) begin
                act_q[i] <= UNITY;
                pnd_q[i] <= '0;
            end
            pending_q <= 1'b0;
        end else begin
            if (sof_acc && pending_q) begin
                act_q     <= pnd_q;
                pending_q <= 1'b0;
            end
            if (gain_update) begin
                pnd_q     <= gain_in;
                pending_q <= 1'b1;
            end
        end
    end

    // Valid and sideband flags follow the data through both stages.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_d1_q <= 1'b0;
            valid_d2_q <= 1'b0;
            flags_d1_q <= '0;
            flags_d2_q <= '0;
        end else begin
            if (ready_d1) valid_d1_q <= axis.s_axis_tvalid;
            if (en_d1)    flags_d1_q <= '{tuser: axis.s_axis_tuser, tlast: axis.s_axis_tlast};
            if (ready_d2) valid_d2_q <= valid_d1_q;
            if (en_d2)    flags_d2_q <= flags_d1_q;
        end
    end

    for (genvar c = 0; c < 3; c++) begin : g_chan
        pwbal_chan #(
            .C_PIXEL_WIDTH (C_PIXEL_WIDTH),
            .C_GAIN_WIDTH  (C_GAIN_WIDTH),
            .C_GAIN_FRAC   (C_GAIN_FRAC)
        ) u_chan (
            .clk     (clk),
            .resetn  (resetn),
            .en_d1_i (en_d1),
            .en_d2_i (en_d2),
            .pix_i   (axis.s_axis_tdata[(2-c)*C_PIXEL_WIDTH +: C_PIXEL_WIDTH]),
            .gain_i  (gain_sel[c]),
            .q_o     (q_w[c])
        );
    end

    assign axis.s_axis_tready = ready_d1;
    assign axis.m_axis_tvalid = valid_d2_q;
    assign axis.m_axis_tdata  = {q_w[0], q_w[1], q_w[2]};
    assign axis.m_axis_tuser  = flags_d2_q.tuser;
    assign axis.m_axis_tlast  = flags_d2_q.tlast;
    assign gain_pending       = pending_q;

endmodule
